ram512_arbiter: RTL



---
 rtl/ram512_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ram512_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram512_arbiter
// Purpose  : Two-requester front-end for a 512x16 RAM with a single
//            in/load/address/out port. After reset it clears every word,
//            then serves the requesters round-robin, one access per cycle.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN   requester N access request (held until gntN)
//   gntN                       requester N access issued this cycle
//   rvalidN, rdataN            requester N read data (rvalid is one cycle)
//   ready                      clear sweep done, arbiter serving
//   ram_in, ram_load,
//   ram_address, ram_out       RAM port (write at the clock edge,
//                              ram_out is the combinational read)
// ============================================================================
module ram512_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic             ready,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_LAST_ADDR = '1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_last_addr;
  logic            r_ptr;       // requester favoured when both request

  // State register plus all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_START;
      r_cnt       <= '0;
      r_last_addr <= '0;
      r_ptr       <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // When nothing is granted ram_address already equals r_last_addr,
      // so tracking it every cycle gives the hold behaviour for free.
      r_last_addr <= ram_address;
      if (gnt0) begin
        r_ptr <= 1'b1;
      end else if (gnt1) begin
        r_ptr <= 1'b0;
      end
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) begin
        rdata0 <= ram_out;
      end
      if (gnt1 && !we1) begin
        rdata1 <= ram_out;
      end
    end
  end

  // Next state, arbitration and RAM port drive.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_load    = 1'b0;
    ram_in      = '0;
    ram_address = r_last_addr;
    case (r_state)
      ST_START: begin
        ram_address = r_cnt;
        w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        ram_load    = 1'b1;
        ram_address = r_cnt;
        if (r_cnt == C_LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        gnt0  = req0 & (~req1 | ~r_ptr);
        gnt1  = req1 & (~req0 |  r_ptr);
        if (gnt0) begin
          ram_address = addr0;
          ram_load    = we0;
          ram_in      = we0 ? wdata0 : '0;
        end else if (gnt1) begin
          ram_address = addr1;
          ram_load    = we1;
          ram_in      = we1 ? wdata1 : '0;
        end
      end
      default: begin
        w_state_nxt = ST_START;
      end
    endcase
  end

endmodule
`default_nettype wire
